bank_cmd_arbiter: RTL and testbench

//  Consumer end of the bank machine command stream. Arbitrates NBANKS
//  cmd_valid/cmd_ready streams round-robin and enforces the CAS-to-CAS (tCCD)
//  and ACT-to-ACT (tRRD) gaps. Registers the winning command towards the PHY

---
 rtl/bank_cmd_arbiter.sv | 158 +++++++++++++++
 tb/tb_bank_cmd_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_arbiter.sv
// Round-robin bank command arbiter with tCCD/tRRD spacing and refresh handshake;
// winner registered to the PHY slot with 1-cycle latency, PHY never backpressures.
module bank_cmd_arbiter #(
   parameter int NBANKS    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [NBANKS-1:0]    bm_cmd_valid,
   output logic [NBANKS-1:0]    bm_cmd_ready,
   output logic [NBANKS-1:0]    bm_cmd_first,
   output logic [NBANKS-1:0]    bm_cmd_last,
   input  logic [17*NBANKS-1:0] bm_cmd_a,
   input  logic [3*NBANKS-1:0]  bm_cmd_ba,
   input  logic [NBANKS-1:0]    bm_cmd_cas,
   input  logic [NBANKS-1:0]    bm_cmd_ras,
   input  logic [NBANKS-1:0]    bm_cmd_we,
   input  logic [NBANKS-1:0]    bm_cmd_is_cmd,
   input  logic [NBANKS-1:0]    bm_cmd_is_read,
   input  logic [NBANKS-1:0]    bm_cmd_is_write,
   output logic [NBANKS-1:0]    bm_refresh_req,
   input  logic [NBANKS-1:0]    bm_refresh_gnt,
   input  logic                 ref_req,
   output logic                 ref_gnt,
   input  logic [7:0]           tccd_cfg,
   input  logic [7:0]           trrd_cfg,
   output logic                 phy_valid,
   output logic [16:0]          phy_a,
   output logic [2:0]           phy_ba,
   output logic                 phy_cas,
   output logic                 phy_ras,
   output logic                 phy_we,
   output logic                 phy_is_read,
   output logic                 phy_is_write
);

   localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   localparam logic [1:0] ST_ARB      = 2'd0;
   localparam logic [1:0] ST_REF_WAIT = 2'd1;
   localparam logic [1:0] ST_REF_GNT  = 2'd2;

   logic [1:0]        state, state_nxt;
   logic [BW-1:0]     owner, win_idx, cand;
   logic [CW-1:0]     burst_cnt, cnt_eff;
   logic [7:0]        cas_timer, act_timer;
   logic              fresh;
   logic [NBANKS-1:0] is_cas, is_act, elig;
   logic              keep, found, accept, rotate, first_c, last_c;
   logic              win_cas, win_act;

   function automatic logic [7:0] gap_load(input logic [7:0] cfg);
      return (cfg == 8'd0) ? 8'd0 : cfg - 8'd1;
   endfunction

   always_comb begin
      for (int i = 0; i < NBANKS; i++) begin
         is_cas[i] = bm_cmd_cas[i] & (bm_cmd_is_read[i] | bm_cmd_is_write[i]);
         is_act[i] = bm_cmd_is_cmd[i] & bm_cmd_ras[i] & ~bm_cmd_cas[i] & ~bm_cmd_we[i];
         elig[i]   = bm_cmd_valid[i] & (state == ST_ARB) & ~sys_rst
                     & (~is_cas[i] | (cas_timer == 8'd0))
                     & (~is_act[i] | (act_timer == 8'd0));
      end
   end

   assign keep = elig[owner] && (int'(burst_cnt) < MAX_BURST);

   // Search starts after the owner and ends on the owner itself, so a lone
   // bank that exhausted its burst wins again as a fresh ownership run.
   always_comb begin
      found   = 1'b0;
      cand    = owner;
      win_idx = owner;
      for (int k = 1; k <= NBANKS; k++) begin
         cand = owner + BW'(k);
         if (!found && elig[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
      if (keep) win_idx = owner;
   end

   assign accept  = keep | found;
   assign rotate  = ~keep & found;
   assign first_c = rotate | fresh;
   assign cnt_eff = first_c ? '0 : burst_cnt;
   assign last_c  = (int'(cnt_eff) + 1 == MAX_BURST);
   assign win_cas = is_cas[win_idx];
   assign win_act = is_act[win_idx];

   assign bm_cmd_ready   = accept ? (NBANKS'(1) << win_idx) : '0;
   assign bm_cmd_first   = first_c ? bm_cmd_ready : '0;
   assign bm_cmd_last    = last_c ? bm_cmd_ready : '0;
   assign bm_refresh_req = ((state != ST_ARB) && ref_req && !sys_rst) ? '1 : '0;
   assign ref_gnt        = (state == ST_REF_GNT);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ARB:      if (ref_req) state_nxt = ST_REF_WAIT;
         ST_REF_WAIT: if (!ref_req) state_nxt = ST_ARB;
                      else if (&bm_refresh_gnt) state_nxt = ST_REF_GNT;
         ST_REF_GNT:  if (!ref_req) state_nxt = ST_ARB;
         default:     state_nxt = ST_ARB;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= ST_ARB;
         owner     <= '0;
         burst_cnt <= '0;
         fresh     <= 1'b1;
         cas_timer <= 8'd0;
         act_timer <= 8'd0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner     <= win_idx;
            burst_cnt <= cnt_eff + CW'(1);
         end
         // Any refresh excursion starts a new ownership run on return.
         if (state != ST_ARB) fresh <= 1'b1;
         else if (accept) fresh <= 1'b0;
         if (accept && win_cas) cas_timer <= gap_load(tccd_cfg);
         else if (cas_timer != 8'd0) cas_timer <= cas_timer - 8'd1;
         if (accept && win_act) act_timer <= gap_load(trrd_cfg);
         else if (act_timer != 8'd0) act_timer <= act_timer - 8'd1;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         phy_valid    <= 1'b0;
         phy_a        <= '0;
         phy_ba       <= '0;
         phy_cas      <= 1'b0;
         phy_ras      <= 1'b0;
         phy_we       <= 1'b0;
         phy_is_read  <= 1'b0;
         phy_is_write <= 1'b0;
      end else begin
         phy_valid <= accept;
         if (accept) begin
            phy_a        <= bm_cmd_a[17*int'(win_idx) +: 17];
            phy_ba       <= bm_cmd_ba[3*int'(win_idx) +: 3];
            phy_cas      <= bm_cmd_cas[win_idx];
            phy_ras      <= bm_cmd_ras[win_idx];
            phy_we       <= bm_cmd_we[win_idx];
            phy_is_read  <= bm_cmd_is_read[win_idx];
            phy_is_write <= bm_cmd_is_write[win_idx];
         end
      end
   end

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Bench for bank_cmd_arbiter: directed bank traffic, expected accepts queued
// by the stimulus and checked by negedge monitors; second instance uses MAX_BURST=1.
module tb_bank_cmd_arbiter;
   localparam int NB = 8;
   localparam int T_READ = 0, T_WRITE = 1, T_ACT = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [NB-1:0]    valid, valid1, cas, ras, we, is_cmd, is_read, is_write, gnt;
   logic [17*NB-1:0] a;
   logic [3*NB-1:0]  ba;
   logic             ref_req;
   logic             ref_req1 = 1'b0;
   logic [7:0]       tccd, trrd;

   logic [NB-1:0] ready, first_o, last_o, rreq;
   logic          rgnt, pv, pcas, pras, pwe, prd, pwr;
   logic [16:0]   pa;
   logic [2:0]    pba;

   logic [NB-1:0] ready1, first1, last1, rreq1;
   logic          rgnt1, pv1, pcas1, pras1, pwe1, prd1, pwr1;
   logic [16:0]   pa1;
   logic [2:0]    pba1;

   bank_cmd_arbiter #(.NBANKS(NB), .MAX_BURST(4)) dut (
      .sys_clk(clk), .sys_rst(rst), .bm_cmd_valid(valid), .bm_cmd_ready(ready),
      .bm_cmd_first(first_o), .bm_cmd_last(last_o), .bm_cmd_a(a), .bm_cmd_ba(ba),
      .bm_cmd_cas(cas), .bm_cmd_ras(ras), .bm_cmd_we(we), .bm_cmd_is_cmd(is_cmd),
      .bm_cmd_is_read(is_read), .bm_cmd_is_write(is_write), .bm_refresh_req(rreq),
      .bm_refresh_gnt(gnt), .ref_req(ref_req), .ref_gnt(rgnt), .tccd_cfg(tccd),
      .trrd_cfg(trrd), .phy_valid(pv), .phy_a(pa), .phy_ba(pba), .phy_cas(pcas),
      .phy_ras(pras), .phy_we(pwe), .phy_is_read(prd), .phy_is_write(pwr));

   bank_cmd_arbiter #(.NBANKS(NB), .MAX_BURST(1)) dut_b1 (
      .sys_clk(clk), .sys_rst(rst), .bm_cmd_valid(valid1), .bm_cmd_ready(ready1),
      .bm_cmd_first(first1), .bm_cmd_last(last1), .bm_cmd_a(a), .bm_cmd_ba(ba),
      .bm_cmd_cas(cas), .bm_cmd_ras(ras), .bm_cmd_we(we), .bm_cmd_is_cmd(is_cmd),
      .bm_cmd_is_read(is_read), .bm_cmd_is_write(is_write), .bm_refresh_req(rreq1),
      .bm_refresh_gnt(gnt), .ref_req(ref_req1), .ref_gnt(rgnt1), .tccd_cfg(tccd),
      .trrd_cfg(trrd), .phy_valid(pv1), .phy_a(pa1), .phy_ba(pba1), .phy_cas(pcas1),
      .phy_ras(pras1), .phy_we(pwe1), .phy_is_read(prd1), .phy_is_write(pwr1));

   typedef struct { int bank; bit first; bit last; int at; } exp_t;
   exp_t q[$];
   exp_t q1[$];
   int checks = 0, errors = 0;
   int cnt [NB];
   int typ [NB];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [16:0] addr_of(input int i);
      return {3'(i), 6'd0, 8'(cnt[i])};
   endfunction

   function automatic logic [4:0] flags_of(input int i);
      case (typ[i])
         T_READ:  return 5'b10010;
         T_WRITE: return 5'b10101;
         default: return 5'b01000;
      endcase
   endfunction

   function automatic int idx_of(input logic [NB-1:0] v);
      for (int i = 0; i < NB; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < NB; i++) begin
         valid[i]        = (cnt[i] > 0);
         a[17*i +: 17]   = addr_of(i);
         ba[3*i +: 3]    = 3'(7 - i);
         cas[i]          = (typ[i] != T_ACT);
         ras[i]          = (typ[i] == T_ACT);
         we[i]           = (typ[i] == T_WRITE);
         is_cmd[i]       = 1'b1;
         is_read[i]      = (typ[i] == T_READ);
         is_write[i]     = (typ[i] == T_WRITE);
      end
   endtask

   // Each bank retires one command per accept seen on the preceding negedge.
   task automatic step(input int n);
      logic [NB-1:0] acc;
      for (int s = 0; s < n; s++) begin
         @(negedge clk);
         acc = valid & ready & {NB{~rst}};
         @(posedge clk);
         #1;
         for (int i = 0; i < NB; i++) if (acc[i]) cnt[i]--;
         drive();
      end
   endtask

   task automatic exp_acc(input int bank, input bit f, input bit l, input int at);
      exp_t e;
      e.bank = bank; e.first = f; e.last = l; e.at = at;
      q.push_back(e);
   endtask

   initial begin : mon
      logic          ev;
      logic [16:0]   ea;
      logic [2:0]    eba;
      logic [4:0]    efl;
      logic [NB-1:0] acc;
      exp_t          e;
      int            b;
      ev = 1'b0; ea = '0; eba = '0; efl = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ev = 1'b0; ea = '0; eba = '0; efl = '0;
            continue;
         end
         check("phy_valid", pv, ev);
         check("phy_a", pa, ea);
         check("phy_ba", pba, eba);
         check("phy_flags", {pcas, pras, pwe, prd, pwr}, efl);
         acc = valid & ready;
         ev = 1'b0;
         if (acc != '0) begin
            b = idx_of(acc);
            check("ready_onehot", 32'($onehot(ready)), 1);
            if (q.size() == 0) begin
               check("unexpected_accept", acc, 0);
            end else begin
               e = q.pop_front();
               check("accept_bank", b, e.bank);
               check("accept_cycle", cyc, e.at);
               check("accept_first", first_o, e.first ? acc : '0);
               check("accept_last", last_o, e.last ? acc : '0);
            end
            ev = 1'b1; ea = addr_of(b); eba = 3'(7 - b); efl = flags_of(b);
         end
      end
   end

   initial begin : mon1
      logic          ev;
      logic [2:0]    eba;
      logic [NB-1:0] acc;
      exp_t          e;
      int            b;
      ev = 1'b0; eba = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ev = 1'b0;
            continue;
         end
         check("b1_phy_valid", pv1, ev);
         if (ev) check("b1_phy_ba", pba1, eba);
         acc = valid1 & ready1;
         ev = 1'b0;
         if (acc != '0) begin
            b = idx_of(acc);
            if (q1.size() == 0) begin
               check("b1_unexpected_accept", acc, 0);
            end else begin
               e = q1.pop_front();
               check("b1_accept_bank", b, e.bank);
               check("b1_accept_cycle", cyc, e.at);
               check("b1_first", first1, e.first ? acc : '0);
               check("b1_last", last1, e.last ? acc : '0);
            end
            ev = 1'b1; eba = 3'(7 - b);
         end
      end
   end

   initial begin : stim
      int   base;
      exp_t e;
      rst = 1'b1; ref_req = 1'b0; gnt = '0; tccd = 8'd0; trrd = 8'd0; valid1 = '0;
      for (int i = 0; i < NB; i++) begin
         cnt[i] = 0;
         typ[i] = T_READ;
      end
      drive();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready, 0);
      check("rst_first_last", {first_o, last_o}, 0);
      check("rst_phy", {pv, pa, pba, pcas, pras, pwe, prd, pwr}, 0);
      check("rst_refresh", {rreq, rgnt}, 0);
      rst = 1'b0;
      step(2);

      // T1: round robin 0,1,2 with MAX_BURST=1
      valid1 = 8'b0000_0111;
      base = cyc;
      for (int k = 0; k < 7; k++) begin
         e.bank = k % 3; e.first = 1'b1; e.last = 1'b1; e.at = base + k;
         q1.push_back(e);
      end
      step(7);
      valid1 = '0;
      step(2);

      // T2: lone bank 3, 6 writes, burst of 4 then a new run
      typ[3] = T_WRITE; cnt[3] = 6; drive();
      base = cyc;
      exp_acc(3, 1, 0, base);     exp_acc(3, 0, 0, base + 1);
      exp_acc(3, 0, 0, base + 2); exp_acc(3, 0, 1, base + 3);
      exp_acc(3, 1, 0, base + 4); exp_acc(3, 0, 0, base + 5);
      step(8);

      // T3: tCCD=4, reads on banks 4/5, ACT on bank 1 fills the gap
      tccd = 8'd4; trrd = 8'd0;
      typ[4] = T_READ; typ[5] = T_READ; typ[1] = T_ACT;
      cnt[4] = 2; cnt[5] = 2; cnt[1] = 1; drive();
      base = cyc;
      exp_acc(4, 1, 0, base);     exp_acc(1, 1, 0, base + 1);
      exp_acc(4, 1, 0, base + 4); exp_acc(5, 1, 0, base + 8);
      exp_acc(5, 0, 0, base + 12);
      step(18);

      // T4: tRRD=3, ACTs on banks 5 and 0, read on bank 2 not delayed
      tccd = 8'd0; trrd = 8'd3;
      typ[0] = T_ACT; typ[5] = T_ACT; typ[2] = T_READ;
      cnt[0] = 1; cnt[5] = 1; cnt[2] = 1; drive();
      base = cyc;
      exp_acc(5, 0, 0, base); exp_acc(2, 1, 0, base + 1); exp_acc(0, 1, 0, base + 3);
      step(6);

      // T5: refresh during bank 6 traffic
      typ[6] = T_WRITE; cnt[6] = 5; drive();
      base = cyc;
      exp_acc(6, 1, 0, base); exp_acc(6, 0, 0, base + 1); exp_acc(6, 0, 0, base + 2);
      step(2);
      ref_req = 1'b1;
      step(1);
      check("ref_wait_req", rreq, 8'hFF);
      check("ref_wait_gnt", rgnt, 0);
      step(2);
      gnt = 8'h0F;
      step(1);
      check("ref_partial_gnt", rgnt, 0);
      gnt = 8'hFF;
      #1;
      check("ref_gnt_same_cycle", rgnt, 0);
      step(1);
      check("ref_gnt_rise", rgnt, 1);
      check("ref_gnt_req_held", rreq, 8'hFF);
      step(2);
      ref_req = 1'b0;
      base = cyc;
      exp_acc(6, 1, 0, base + 1); exp_acc(6, 0, 0, base + 2);
      step(1);
      check("ref_exit_gnt", rgnt, 0);
      check("ref_exit_req", rreq, 0);
      gnt = '0;
      step(4);

      // T6: async reset mid-burst, next grant to bank 0
      typ[2] = T_WRITE; cnt[2] = 6; typ[0] = T_WRITE; drive();
      base = cyc;
      exp_acc(2, 1, 0, base);
      step(1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_ready", ready, 0);
      check("arst_first_last", {first_o, last_o}, 0);
      check("arst_phy", {pv, pa, pba, pcas, pras, pwe, prd, pwr}, 0);
      check("arst_refresh", {rreq, rgnt}, 0);
      cnt[0] = 1; drive();
      step(1);
      #2;
      rst = 1'b0;
      base = cyc;
      exp_acc(0, 1, 0, base);     exp_acc(2, 1, 0, base + 1);
      exp_acc(2, 0, 0, base + 2); exp_acc(2, 0, 0, base + 3);
      exp_acc(2, 0, 1, base + 4); exp_acc(2, 1, 0, base + 5);
      step(9);

      check("queue_drain", q.size() + q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
